// File: rtl/load_unit_pkg.sv
// Shared types and sizing for the load execute stage.
package load_unit_pkg;

    localparam int WORD_SIZE_P = 16;
    localparam int SB_ENTRY    = 8;
    localparam int ROB_ENTRY   = 16;

    localparam int SB_NUM_W  = $clog2(SB_ENTRY);
    localparam int ROB_TAG_W = $clog2(ROB_ENTRY);

    // Write-back word placed on the common data bus.
    typedef struct packed {
        logic [ROB_TAG_W-1:0]   rob_dest;
        logic [WORD_SIZE_P-1:0] result;
    } CDB_ld_t;

    localparam int CDB_LD_WIDTH = $bits(CDB_ld_t);

    // Stage B occupancy: FRESH means memory data is on the read bus this
    // cycle, HELD means the result has been captured locally.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } b_state_t;

endpackage

// File: rtl/load_unit.sv
// Two-stage load pipeline: address generation (A) and memory/bypass
// write-back (B) with a CDB grant handshake and mispredict flush.
module load_unit
    import load_unit_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rob_mispredict_i,
    input  logic                    issue_ld_v_i,
    input  logic [WORD_SIZE_P-1:0]  issue_ld_base_i,
    input  logic [WORD_SIZE_P-1:0]  issue_ld_offset_i,
    input  logic [SB_NUM_W-1:0]     issue_ld_sb_num_i,
    input  logic [ROB_TAG_W-1:0]    issue_ld_rob_dest_i,
    output logic                    ld_issue_ready_o,
    output logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_o,
    output logic [SB_NUM_W-1:0]     exe_ld_pass_sb_num_o,
    input  logic                    sb_ld_pass_valid_i,
    input  logic [WORD_SIZE_P-1:0]  sb_ld_pass_value_i,
    output logic                    mem_rd_v_o,
    output logic [WORD_SIZE_P-1:0]  mem_rd_addr_o,
    input  logic [WORD_SIZE_P-1:0]  mem_rd_data_i,
    output logic                    ld_cdb_v_o,
    output logic [CDB_LD_WIDTH-1:0] ld_cdb_o,
    input  logic                    ld_cdb_grant_i
);

    // Stage A
    logic                   vld_p0;
    logic [WORD_SIZE_P-1:0] addr_p0;
    logic [SB_NUM_W-1:0]    sb_num_p0;
    logic [ROB_TAG_W-1:0]   rob_dest_p0;

    // Stage B
    b_state_t               state_p1;
    b_state_t               state_next_p1;
    logic                   hit_p1;
    logic [WORD_SIZE_P-1:0] bypass_p1;
    logic [WORD_SIZE_P-1:0] held_p1;
    logic [ROB_TAG_W-1:0]   rob_dest_p1;

    logic                   granted;
    logic                   a_move;
    logic                   accept;
    logic [WORD_SIZE_P-1:0] result;
    CDB_ld_t                cdb;

    assign ld_cdb_v_o       = (state_p1 != EMPTY) & ~rob_mispredict_i;
    assign granted          = ld_cdb_v_o & ld_cdb_grant_i;
    assign a_move           = vld_p0 & ((state_p1 == EMPTY) | granted);
    assign ld_issue_ready_o = (~vld_p0 | a_move) & ~rob_mispredict_i;
    assign accept           = issue_ld_v_i & ld_issue_ready_o;

    assign mem_rd_v_o           = a_move & ~rob_mispredict_i;
    assign mem_rd_addr_o        = addr_p0;
    assign exe_ld_bypass_addr_o = addr_p0;
    assign exe_ld_pass_sb_num_o = sb_num_p0;

    // Stage A register: capture the issued load and its wrapped effective address
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p0      <= 1'b0;
            addr_p0     <= '0;
            sb_num_p0   <= '0;
            rob_dest_p0 <= '0;
        end else if (rob_mispredict_i) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0      <= 1'b1;
            addr_p0     <= issue_ld_base_i + issue_ld_offset_i;
            sb_num_p0   <= issue_ld_sb_num_i;
            rob_dest_p0 <= issue_ld_rob_dest_i;
        end else if (a_move) begin
            vld_p0 <= 1'b0;
        end
    end

    // Stage B state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_p1 <= EMPTY;
        else         state_p1 <= state_next_p1;
    end

    // Stage B next state: flush first, then refill, drain, or hold un-granted data
    always_comb begin
        state_next_p1 = state_p1;
        if (rob_mispredict_i)                      state_next_p1 = EMPTY;
        else if (a_move)                           state_next_p1 = FRESH;
        else if (granted)                          state_next_p1 = EMPTY;
        else if (state_p1 == FRESH)                state_next_p1 = HELD;
    end

    // Stage B payload: bypass sample on entry, result latch when FRESH is not granted
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_p1      <= 1'b0;
            bypass_p1   <= '0;
            held_p1     <= '0;
            rob_dest_p1 <= '0;
        end else if (!rob_mispredict_i) begin
            if (a_move) begin
                hit_p1      <= sb_ld_pass_valid_i;
                bypass_p1   <= sb_ld_pass_value_i;
                rob_dest_p1 <= rob_dest_p0;
            end else if (state_p1 == FRESH && !granted) begin
                held_p1 <= result;
            end
        end
    end

    // Result select: memory data is only trusted in the FRESH cycle
    always_comb begin
        result = '0;
        case (state_p1)
            FRESH:   result = hit_p1 ? bypass_p1 : mem_rd_data_i;
            HELD:    result = held_p1;
            default: result = '0;
        endcase
    end

    // CDB word is all-zero whenever stage B is empty
    always_comb begin
        cdb.rob_dest = (state_p1 == EMPTY) ? '0 : rob_dest_p1;
        cdb.result   = result;
    end

    assign ld_cdb_o = cdb;

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit.
module tb_load_unit;
    import load_unit_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic                    rob_mispredict_i;
    logic                    issue_ld_v_i;
    logic [WORD_SIZE_P-1:0]  issue_ld_base_i;
    logic [WORD_SIZE_P-1:0]  issue_ld_offset_i;
    logic [SB_NUM_W-1:0]     issue_ld_sb_num_i;
    logic [ROB_TAG_W-1:0]    issue_ld_rob_dest_i;
    logic                    ld_issue_ready_o;
    logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_o;
    logic [SB_NUM_W-1:0]     exe_ld_pass_sb_num_o;
    logic                    sb_ld_pass_valid_i;
    logic [WORD_SIZE_P-1:0]  sb_ld_pass_value_i;
    logic                    mem_rd_v_o;
    logic [WORD_SIZE_P-1:0]  mem_rd_addr_o;
    logic [WORD_SIZE_P-1:0]  mem_rd_data_i;
    logic                    ld_cdb_v_o;
    logic [CDB_LD_WIDTH-1:0] ld_cdb_o;
    logic                    ld_cdb_grant_i;

    int checks   = 0;
    int failures = 0;

    load_unit dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .rob_mispredict_i     (rob_mispredict_i),
        .issue_ld_v_i         (issue_ld_v_i),
        .issue_ld_base_i      (issue_ld_base_i),
        .issue_ld_offset_i    (issue_ld_offset_i),
        .issue_ld_sb_num_i    (issue_ld_sb_num_i),
        .issue_ld_rob_dest_i  (issue_ld_rob_dest_i),
        .ld_issue_ready_o     (ld_issue_ready_o),
        .exe_ld_bypass_addr_o (exe_ld_bypass_addr_o),
        .exe_ld_pass_sb_num_o (exe_ld_pass_sb_num_o),
        .sb_ld_pass_valid_i   (sb_ld_pass_valid_i),
        .sb_ld_pass_value_i   (sb_ld_pass_value_i),
        .mem_rd_v_o           (mem_rd_v_o),
        .mem_rd_addr_o        (mem_rd_addr_o),
        .mem_rd_data_i        (mem_rd_data_i),
        .ld_cdb_v_o           (ld_cdb_v_o),
        .ld_cdb_o             (ld_cdb_o),
        .ld_cdb_grant_i       (ld_cdb_grant_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed here, outputs checked 2ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic v, input logic [15:0] base, input logic [15:0] off,
                         input logic [2:0] sb, input logic [3:0] rob);
        issue_ld_v_i        = v;
        issue_ld_base_i     = base;
        issue_ld_offset_i   = off;
        issue_ld_sb_num_i   = sb;
        issue_ld_rob_dest_i = rob;
    endtask

    function automatic logic [31:0] cdbw(input logic [3:0] rob, input logic [15:0] val);
        return 32'({rob, val});
    endfunction

    initial begin
        reset_i            = 1'b1;
        rob_mispredict_i   = 1'b0;
        sb_ld_pass_valid_i = 1'b0;
        sb_ld_pass_value_i = '0;
        mem_rd_data_i      = '0;
        ld_cdb_grant_i     = 1'b0;
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        tick();
        tick();
        reset_i = 1'b0;
        settle();

        // Reset state
        chk("rst_ready",   ld_issue_ready_o, 1);
        chk("rst_cdb_v",   ld_cdb_v_o, 0);
        chk("rst_mem_v",   mem_rd_v_o, 0);
        chk("rst_byp",     exe_ld_bypass_addr_o, 0);
        chk("rst_sbnum",   exe_ld_pass_sb_num_o, 0);
        chk("rst_cdb",     ld_cdb_o, 0);

        // Basic load: 0x0010 + 0xFFFE = 0x000E, memory returns 0xBEEF
        ld_cdb_grant_i = 1'b1;
        issue(1'b1, 16'h0010, 16'hFFFE, 3'd2, 4'd7);
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        settle();
        chk("t1_mem_v",    mem_rd_v_o, 1);
        chk("t1_mem_addr", mem_rd_addr_o, 16'h000E);
        chk("t1_byp_addr", exe_ld_bypass_addr_o, 16'h000E);
        chk("t1_sbnum",    exe_ld_pass_sb_num_o, 2);
        chk("t1_cdb_v_c1", ld_cdb_v_o, 0);
        tick();
        mem_rd_data_i = 16'hBEEF;
        settle();
        chk("t1_cdb_v",    ld_cdb_v_o, 1);
        chk("t1_cdb",      ld_cdb_o, cdbw(4'd7, 16'hBEEF));
        tick();
        settle();
        chk("t1_drain",    ld_cdb_v_o, 0);

        // Store buffer hit overrides memory data
        issue(1'b1, 16'h0100, 16'h0005, 3'd1, 4'd9);
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        sb_ld_pass_valid_i = 1'b1;
        sb_ld_pass_value_i = 16'h1234;
        settle();
        chk("t2_mem_addr", mem_rd_addr_o, 16'h0105);
        tick();
        sb_ld_pass_valid_i = 1'b0;
        sb_ld_pass_value_i = 16'h0;
        mem_rd_data_i      = 16'hBEEF;
        settle();
        chk("t2_cdb",      ld_cdb_o, cdbw(4'd9, 16'h1234));
        tick();

        // No grant: result held across garbage memory data, second load waits in A
        ld_cdb_grant_i = 1'b0;
        issue(1'b1, 16'h0020, 16'h0000, 3'd0, 4'd1);
        tick();
        issue(1'b1, 16'h0030, 16'h0000, 3'd0, 4'd2);
        settle();
        chk("t3_ready_c1", ld_issue_ready_o, 1);
        chk("t3_addr_c1",  mem_rd_addr_o, 16'h0020);
        tick();
        issue(1'b1, 16'h0090, 16'h0000, 3'd0, 4'd3);
        mem_rd_data_i = 16'hAAAA;
        settle();
        chk("t3_cdb_fresh", ld_cdb_o, cdbw(4'd1, 16'hAAAA));
        chk("t3_ready_full", ld_issue_ready_o, 0);
        chk("t3_mem_v_stall", mem_rd_v_o, 0);
        tick();
        mem_rd_data_i = 16'hDEAD;
        settle();
        chk("t3_cdb_held1", ld_cdb_o, cdbw(4'd1, 16'hAAAA));
        chk("t3_cdb_v_held", ld_cdb_v_o, 1);
        chk("t3_ready_held", ld_issue_ready_o, 0);
        tick();
        mem_rd_data_i = 16'h5A5A;
        settle();
        chk("t3_cdb_held2", ld_cdb_o, cdbw(4'd1, 16'hAAAA));
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        ld_cdb_grant_i = 1'b1;
        mem_rd_data_i  = 16'h0BAD;
        settle();
        chk("t3_cdb_grant", ld_cdb_o, cdbw(4'd1, 16'hAAAA));
        chk("t3_mem_v_mv",  mem_rd_v_o, 1);
        chk("t3_addr_mv",   mem_rd_addr_o, 16'h0030);
        chk("t3_ready_mv",  ld_issue_ready_o, 1);
        tick();
        mem_rd_data_i = 16'h2222;
        settle();
        chk("t3_cdb_second", ld_cdb_o, cdbw(4'd2, 16'h2222));
        tick();
        settle();
        chk("t3_drain", ld_cdb_v_o, 0);

        // Back-to-back loads with continuous grant, tags 3, 4, 5
        issue(1'b1, 16'h0040, 16'h0000, 3'd0, 4'd3);
        tick();
        issue(1'b1, 16'h0041, 16'h0000, 3'd0, 4'd4);
        settle();
        chk("t4_addr3", mem_rd_addr_o, 16'h0040);
        tick();
        issue(1'b1, 16'h0042, 16'h0000, 3'd0, 4'd5);
        mem_rd_data_i = 16'h3333;
        settle();
        chk("t4_cdb3",  ld_cdb_o, cdbw(4'd3, 16'h3333));
        chk("t4_addr4", mem_rd_addr_o, 16'h0041);
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        mem_rd_data_i = 16'h4444;
        settle();
        chk("t4_cdb4",  ld_cdb_o, cdbw(4'd4, 16'h4444));
        chk("t4_addr5", mem_rd_addr_o, 16'h0042);
        tick();
        mem_rd_data_i = 16'h5555;
        settle();
        chk("t4_cdb5",   ld_cdb_o, cdbw(4'd5, 16'h5555));
        chk("t4_mem_v0", mem_rd_v_o, 0);
        tick();
        settle();
        chk("t4_drain", ld_cdb_v_o, 0);

        // Mispredict with A and B both full, grant asserted in the same cycle
        ld_cdb_grant_i = 1'b0;
        issue(1'b1, 16'h0050, 16'h0000, 3'd0, 4'd6);
        tick();
        issue(1'b1, 16'h0060, 16'h0000, 3'd0, 4'd7);
        tick();
        issue(1'b1, 16'h0070, 16'h0000, 3'd0, 4'd8);
        mem_rd_data_i    = 16'h6666;
        ld_cdb_grant_i   = 1'b1;
        rob_mispredict_i = 1'b1;
        settle();
        chk("t5_cdb_v",  ld_cdb_v_o, 0);
        chk("t5_mem_v",  mem_rd_v_o, 0);
        chk("t5_ready",  ld_issue_ready_o, 0);
        tick();
        rob_mispredict_i = 1'b0;
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        settle();
        chk("t5_ready_after", ld_issue_ready_o, 1);
        chk("t5_cdb_v_after", ld_cdb_v_o, 0);
        chk("t5_mem_v_after", mem_rd_v_o, 0);
        tick();
        settle();
        chk("t5_cdb_v_later", ld_cdb_v_o, 0);

        // Address wrap: 0xFFFF + 0x0002 = 0x0001
        issue(1'b1, 16'hFFFF, 16'h0002, 3'd3, 4'd10);
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        settle();
        chk("t6_addr_wrap", mem_rd_addr_o, 16'h0001);
        tick();
        mem_rd_data_i = 16'h0F0F;
        settle();
        chk("t6_cdb", ld_cdb_o, cdbw(4'd10, 16'h0F0F));
        tick();

        // Reset mid-operation restores reset values
        issue(1'b1, 16'h0077, 16'h0000, 3'd5, 4'd11);
        tick();
        issue(1'b0, 16'h0, 16'h0, 3'd0, 4'd0);
        reset_i = 1'b1;
        tick();
        settle();
        chk("t7_cdb_v",  ld_cdb_v_o, 0);
        chk("t7_mem_v",  mem_rd_v_o, 0);
        chk("t7_byp",    exe_ld_bypass_addr_o, 0);
        chk("t7_sbnum",  exe_ld_pass_sb_num_o, 0);
        chk("t7_cdb",    ld_cdb_o, 0);
        chk("t7_ready",  ld_issue_ready_o, 1);
        reset_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
